bram_pingpong_buf: RTL and testbench
====================================

// Module: bram_pingpong_buf
// PURPOSE
//   Double-buffered (ping-pong) on-chip word buffer between the tile loader (producer,
//   fills B-blocks row by row from DMA) and the compute consumer. Two banks of DEPTH words:
//   one bank is filled while the other is read. Per-bank state tracking handles full/empty
//   hand-off. Bank completion is signalled by fill_done and consume_done pulses.
// PARAMETERS
//   DATA_W           32   word width
//   DEPTH            256  words per bank; AW = $clog2(DEPTH)
//   USE_CONS_COMMIT  1    1: consume ends on cons_commit; 0: consume ends after seg_words reads
// PORTS
//   clk          in   1       single clock, all logic on posedge
//   rst          in   1       synchronous reset, active-high
//   seg_words    in   32      words per segment (fill/consume length); sampled at fill/consume start
//   fill_req     in   1       request to start filling next bank (pulse)
//   fill_busy    out  1       fill in progress
//   fill_we      in   1       write strobe (honoured only while fill_busy)
//   fill_addr    in   AW      write word address within fill bank
//   fill_wdata   in   DATA_W  write data
//   fill_done    out  1       1-cycle pulse: segment fill complete, bank now FULL
//   consume_req  in   1       request to start consuming next FULL bank (pulse)
//   consume_busy out  1       consume in progress
//   rd_addr      in   AW      read word address within consume bank
//   rd_en        in   1       read strobe
//   rd_rdata     out  DATA_W  read data, registered
//   cons_commit  in   1       consumer releases bank (USE_CONS_COMMIT=1)
//   consume_done out  1       1-cycle pulse: bank released, now EMPTY
//   bank_sel     out  1       index of bank currently owned by consumer (cons_ptr)
// BEHAVIOUR
//   - Reset: both banks EMPTY; fill_ptr=0, cons_ptr=0; all outputs 0 (rd_rdata=0); pending reqs cleared.
//     Reset mid-operation aborts fill/consume; memory contents are not cleared.
//   - Bank state per bank: EMPTY -> FILLING -> FULL -> CONSUMING -> EMPTY.
//   - Fill: fill_req sets fill_pend. When fill_pend && bank[fill_ptr]==EMPTY && !fill_busy: next cycle
//     fill_busy=1, bank FILLING, fill_cnt=0, seg latched (seg_words==0 treated as DEPTH).
//   - While fill_busy, each fill_we writes mem[fill_ptr][fill_addr] and increments 32-bit fill_cnt.
//     seg may exceed DEPTH; caller wraps fill_addr, buffer does not check. fill_we outside fill_busy ignored.
//   - On the write making fill_cnt==seg: next cycle fill_done=1 (one cycle), fill_busy=0,
//     bank FULL, fill_ptr toggles.
//   - Consume: consume_req sets cons_pend. When cons_pend && bank[cons_ptr]==FULL && !consume_busy:
//     next cycle consume_busy=1, bank CONSUMING. A FULL bank reached in the same cycle as
//     consume_req is picked up one cycle later; no request is lost.
//   - Read: rd_en samples rd_addr; rd_rdata = mem[cons_ptr][rd_addr] one cycle later (1-cycle latency),
//     holds otherwise. Reads legal only while consume_busy.
//   - End of consume, USE_CONS_COMMIT=1: cons_commit while consume_busy. USE_CONS_COMMIT=0: read count
//     reaches seg. Next cycle: consume_done=1 (one cycle), consume_busy=0, bank EMPTY, cons_ptr toggles.
//     cons_commit outside consume_busy ignored.
//   - Fill and consume run concurrently on opposite banks. A simultaneous fill_done and
//     consume_done are independent. bank_sel=cons_ptr at all times.
//   - Full: both banks FULL/CONSUMING -> fill waits (fill_pend held).
//     Empty: both EMPTY/FILLING -> consume waits.
// TESTING
//   1 Reset -> all outputs 0, bank_sel=0; fill_we before fill_req writes nothing.
//   2 seg_words=16, fill_req, 16 writes -> fill_done exactly one cycle after 16th write;
//     fill_busy low afterwards; consume_req, read addr 0..15 -> data matches with 1-cycle latency.
//   3 seg_words=49152, addr wrapping mod 256 -> fill_done after 49152 writes; 12 back-to-back
//     fills alternating with commits -> 12 fill_done pulses.
//   4 Fill bank0 and bank1 without consuming; third fill_req -> fill_busy stays low until
//     cons_commit frees bank0. Then fill starts, bank_sel=1.
//   5 USE_CONS_COMMIT=0, seg_words=8: 8 rd_en pulses -> consume_done one cycle later, bank_sel toggles.
//   6 rst asserted mid-fill -> fill_busy=0, banks EMPTY; a fresh fill works.

Source files
------------

// File: rtl/bram_pingpong_buf_if.sv
// Fill/consume bus of the ping-pong word buffer.
// master: loader+consumer side; slave: buffer side (fill_*, rd_*, commit, status).
interface bram_pingpong_buf_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 8
);
    logic [31:0]       seg_words;
    logic              fill_req;
    logic              fill_busy;
    logic              fill_we;
    logic [AW-1:0]     fill_addr;
    logic [DATA_W-1:0] fill_wdata;
    logic              fill_done;
    logic              consume_req;
    logic              consume_busy;
    logic [AW-1:0]     rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_rdata;
    logic              cons_commit;
    logic              consume_done;
    logic              bank_sel;

    modport master (
        output seg_words, fill_req, fill_we, fill_addr, fill_wdata,
        output consume_req, rd_addr, rd_en, cons_commit,
        input  fill_busy, fill_done, consume_busy, rd_rdata,
        input  consume_done, bank_sel
    );

    modport slave (
        input  seg_words, fill_req, fill_we, fill_addr, fill_wdata,
        input  consume_req, rd_addr, rd_en, cons_commit,
        output fill_busy, fill_done, consume_busy, rd_rdata,
        output consume_done, bank_sel
    );
endinterface

// File: rtl/bram_pingpong_buf.sv
// Two-bank ping-pong word buffer: one bank fills while the other is read.
// Ports: clk, rst (sync, active-high), bus (slave side of bram_pingpong_buf_if).
module bram_pingpong_buf #(
    parameter int DATA_W          = 32,
    parameter int DEPTH           = 256,
    parameter int USE_CONS_COMMIT = 1,
    localparam int AW             = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    bram_pingpong_buf_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        CONSUMING
    } bank_state_t;

    bank_state_t       bank_st [2];
    logic              fill_ptr;
    logic              cons_ptr;
    logic              fill_pend;
    logic              cons_pend;
    logic [31:0]       fill_cnt;
    logic [31:0]       fill_seg;
    logic [31:0]       rd_cnt;
    logic [31:0]       cons_seg;
    logic [DATA_W-1:0] mem [2*DEPTH];

    logic fill_wr;
    logic fill_last;
    logic fill_start;
    logic cons_rd;
    logic cons_start;
    logic cons_end;
    logic [31:0] seg_len;

    // A zero segment length means a whole bank.
    assign seg_len = (bus.seg_words == 32'd0) ? 32'(DEPTH) : bus.seg_words;

    assign fill_wr    = bus.fill_busy && bus.fill_we;
    assign fill_last  = fill_wr && (fill_cnt + 32'd1 == fill_seg);
    assign fill_start = fill_pend && !bus.fill_busy
                        && (bank_st[fill_ptr] == EMPTY);

    assign cons_rd    = bus.consume_busy && bus.rd_en;
    assign cons_start = cons_pend && !bus.consume_busy
                        && (bank_st[cons_ptr] == FULL);
    assign cons_end   = (USE_CONS_COMMIT != 0)
                        ? (bus.consume_busy && bus.cons_commit)
                        : (cons_rd && (rd_cnt + 32'd1 == cons_seg));

    assign bus.bank_sel = cons_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_st[0]       <= EMPTY;
            bank_st[1]       <= EMPTY;
            fill_ptr         <= 1'b0;
            cons_ptr         <= 1'b0;
            fill_pend        <= 1'b0;
            cons_pend        <= 1'b0;
            fill_cnt         <= '0;
            fill_seg         <= '0;
            rd_cnt           <= '0;
            cons_seg         <= '0;
            bus.fill_busy    <= 1'b0;
            bus.fill_done    <= 1'b0;
            bus.consume_busy <= 1'b0;
            bus.consume_done <= 1'b0;
        end else begin
            bus.fill_done    <= 1'b0;
            bus.consume_done <= 1'b0;

            // A request arriving on the start cycle stays pending.
            if (fill_start) begin
                fill_pend          <= bus.fill_req;
                bus.fill_busy      <= 1'b1;
                bank_st[fill_ptr]  <= FILLING;
                fill_cnt           <= '0;
                fill_seg           <= seg_len;
            end else if (bus.fill_req) begin
                fill_pend <= 1'b1;
            end

            if (fill_wr) begin
                fill_cnt <= fill_cnt + 32'd1;
            end
            if (fill_last) begin
                bus.fill_done     <= 1'b1;
                bus.fill_busy     <= 1'b0;
                bank_st[fill_ptr] <= FULL;
                fill_ptr          <= ~fill_ptr;
            end

            if (cons_start) begin
                cons_pend          <= bus.consume_req;
                bus.consume_busy   <= 1'b1;
                bank_st[cons_ptr]  <= CONSUMING;
                rd_cnt             <= '0;
                cons_seg           <= seg_len;
            end else if (bus.consume_req) begin
                cons_pend <= 1'b1;
            end

            if (cons_rd) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (cons_end) begin
                bus.consume_done  <= 1'b1;
                bus.consume_busy  <= 1'b0;
                bank_st[cons_ptr] <= EMPTY;
                cons_ptr          <= ~cons_ptr;
            end
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            mem[{fill_ptr, bus.fill_addr}] <= bus.fill_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_rdata <= '0;
        end else if (bus.rd_en) begin
            bus.rd_rdata <= mem[{cons_ptr, bus.rd_addr}];
        end
    end
endmodule

// File: tb/tb_bram_pingpong_buf.sv
// Directed bench for bram_pingpong_buf (commit-ended and count-ended).
// Drives two DUT instances through one shared clock and reset.
module tb_bram_pingpong_buf;
    logic clk = 1'b0;
    logic rst;
    int   n_run  = 0;
    int   n_fail = 0;
    int   fd_cnt;

    always #5 clk = ~clk;

    bram_pingpong_buf_if #(.DATA_W(32), .AW(8)) if0 ();
    bram_pingpong_buf_if #(.DATA_W(32), .AW(8)) if1 ();

    bram_pingpong_buf #(.USE_CONS_COMMIT(1)) u_commit (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    bram_pingpong_buf #(.USE_CONS_COMMIT(0)) u_count (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill0(input logic [31:0] seg, input int nwr,
                         input logic [31:0] base, input string tag);
        if0.seg_words = seg;
        if0.fill_req  = 1'b1;
        tick();
        if0.fill_req = 1'b0;
        for (int k = 0; k < 20 && !if0.fill_busy; k++) tick();
        check({tag, "_start"}, 32'(if0.fill_busy), 32'd1);
        for (int i = 0; i < nwr; i++) begin
            if0.fill_we    = 1'b1;
            if0.fill_addr  = 8'(i);
            if0.fill_wdata = base + 32'(i);
            tick();
        end
        if0.fill_we = 1'b0;
    endtask

    task automatic cons0(input string tag);
        if0.consume_req = 1'b1;
        tick();
        if0.consume_req = 1'b0;
        for (int k = 0; k < 20 && !if0.consume_busy; k++) tick();
        check({tag, "_cbusy"}, 32'(if0.consume_busy), 32'd1);
    endtask

    task automatic commit0(input string tag);
        if0.cons_commit = 1'b1;
        tick();
        if0.cons_commit = 1'b0;
        check({tag, "_cdone"}, 32'(if0.consume_done), 32'd1);
        check({tag, "_cidle"}, 32'(if0.consume_busy), 32'd0);
    endtask

    task automatic read0(input int addr, input logic [31:0] exp,
                         input string tag);
        if0.rd_en   = 1'b1;
        if0.rd_addr = 8'(addr);
        tick();
        if0.rd_en = 1'b0;
        check(tag, if0.rd_rdata, exp);
    endtask

    initial begin
        rst = 1'b1;
        if0.seg_words = '0; if0.fill_req = 0; if0.fill_we = 0;
        if0.fill_addr = '0; if0.fill_wdata = '0; if0.consume_req = 0;
        if0.rd_addr = '0; if0.rd_en = 0; if0.cons_commit = 0;
        if1.seg_words = '0; if1.fill_req = 0; if1.fill_we = 0;
        if1.fill_addr = '0; if1.fill_wdata = '0; if1.consume_req = 0;
        if1.rd_addr = '0; if1.rd_en = 0; if1.cons_commit = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_fbusy", 32'(if0.fill_busy), 32'd0);
        check("rst_fdone", 32'(if0.fill_done), 32'd0);
        check("rst_cbusy", 32'(if0.consume_busy), 32'd0);
        check("rst_cdone", 32'(if0.consume_done), 32'd0);
        check("rst_rdata", if0.rd_rdata, 32'd0);
        check("rst_bsel", 32'(if0.bank_sel), 32'd0);

        // 16-word segment, done one cycle after the last write.
        fill0(32'd16, 15, 32'hA000, "t2");
        check("t2_pre_done", 32'(if0.fill_done), 32'd0);
        check("t2_pre_busy", 32'(if0.fill_busy), 32'd1);
        if0.fill_we = 1'b1; if0.fill_addr = 8'd15;
        if0.fill_wdata = 32'hA00F;
        tick();
        if0.fill_we = 1'b0;
        check("t2_done", 32'(if0.fill_done), 32'd1);
        check("t2_fidle", 32'(if0.fill_busy), 32'd0);
        tick();
        check("t2_done_pulse", 32'(if0.fill_done), 32'd0);
        cons0("t2");
        for (int i = 0; i < 16; i++)
            read0(i, 32'hA000 + 32'(i), "t2_rd");
        commit0("t2");
        check("t2_bsel1", 32'(if0.bank_sel), 32'd1);
        fill0(32'd16, 16, 32'hB000, "t2b");
        check("t2b_done", 32'(if0.fill_done), 32'd1);
        cons0("t2b");
        read0(3, 32'hB003, "t2b_rd");
        commit0("t2b");
        check("t2b_bsel0", 32'(if0.bank_sel), 32'd0);

        // Stray write while idle must not reach bank 0.
        if0.fill_we = 1'b1; if0.fill_addr = 8'd5;
        if0.fill_wdata = 32'hDEAD;
        tick();
        if0.fill_we = 1'b0;
        check("t1_stray_fbusy", 32'(if0.fill_busy), 32'd0);
        fill0(32'd4, 4, 32'hC000, "t1s");
        cons0("t1s");
        read0(5, 32'hA005, "t1_stray_ignored");
        read0(2, 32'hC002, "t1s_rd");
        commit0("t1s");

        // Long segment with wrapping address (bank 1).
        fill0(32'd49152, 49152, 32'd0, "t3");
        check("t3_done", 32'(if0.fill_done), 32'd1);
        cons0("t3");
        read0(0, 32'd48896, "t3_rd0");
        read0(255, 32'd49151, "t3_rd255");
        commit0("t3");
        fd_cnt = 0;
        for (int j = 0; j < 12; j++) begin
            fill0(32'd4, 4, 32'(j) << 8, "t3l");
            if (if0.fill_done) fd_cnt++;
            cons0("t3l");
            commit0("t3l");
        end
        check("t3_done_pulses", 32'(fd_cnt), 32'd12);

        // Both banks full: third fill waits for a commit.
        fill0(32'd4, 4, 32'hD000, "t4a");
        tick();
        fill0(32'd4, 4, 32'hE000, "t4b");
        tick();
        if0.fill_req = 1'b1;
        tick();
        if0.fill_req = 1'b0;
        repeat (10) tick();
        check("t4_blocked", 32'(if0.fill_busy), 32'd0);
        cons0("t4");
        check("t4_bsel0", 32'(if0.bank_sel), 32'd0);
        read0(1, 32'hD001, "t4_rd");
        repeat (3) tick();
        check("t4_still_blocked", 32'(if0.fill_busy), 32'd0);
        commit0("t4");
        tick();
        check("t4_resume", 32'(if0.fill_busy), 32'd1);
        check("t4_bsel1", 32'(if0.bank_sel), 32'd1);

        // Reset in the middle of that fill.
        for (int i = 0; i < 2; i++) begin
            if0.fill_we = 1'b1; if0.fill_addr = 8'(i);
            if0.fill_wdata = 32'h1111;
            tick();
        end
        if0.fill_we = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_fbusy", 32'(if0.fill_busy), 32'd0);
        check("t6_cbusy", 32'(if0.consume_busy), 32'd0);
        check("t6_bsel", 32'(if0.bank_sel), 32'd0);
        fill0(32'd4, 4, 32'hF000, "t6");
        check("t6_done", 32'(if0.fill_done), 32'd1);
        cons0("t6");
        read0(1, 32'hF001, "t6_rd");
        commit0("t6");
        if0.consume_req = 1'b1;
        tick();
        if0.consume_req = 1'b0;
        repeat (5) tick();
        check("t6_bank1_empty", 32'(if0.consume_busy), 32'd0);

        // Count-ended consume on the second instance.
        if1.seg_words = 32'd8;
        if1.fill_req  = 1'b1;
        tick();
        if1.fill_req = 1'b0;
        for (int k = 0; k < 20 && !if1.fill_busy; k++) tick();
        check("t5_fstart", 32'(if1.fill_busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if1.fill_we = 1'b1; if1.fill_addr = 8'(i);
            if1.fill_wdata = 32'h5000 + 32'(i);
            tick();
        end
        if1.fill_we = 1'b0;
        check("t5_fdone", 32'(if1.fill_done), 32'd1);
        if1.consume_req = 1'b1;
        tick();
        if1.consume_req = 1'b0;
        for (int k = 0; k < 20 && !if1.consume_busy; k++) tick();
        check("t5_cstart", 32'(if1.consume_busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if1.rd_en = 1'b1; if1.rd_addr = 8'(i);
            tick();
            check("t5_rd", if1.rd_rdata, 32'h5000 + 32'(i));
            if (i == 6)
                check("t5_early", 32'(if1.consume_done), 32'd0);
        end
        if1.rd_en = 1'b0;
        check("t5_cdone", 32'(if1.consume_done), 32'd1);
        check("t5_cidle", 32'(if1.consume_busy), 32'd0);
        check("t5_bsel", 32'(if1.bank_sel), 32'd1);
        tick();
        check("t5_cdone_pulse", 32'(if1.consume_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
